// File: rtl/kv_burst_cache.sv
// kv_burst_cache
//
// Append-only K/V row cache with burst read-out. Rows are appended at address
// `fill` until the cache holds SEQ_LEN rows. A burst request names a start row
// and a row count. The block streams those rows out over a valid/ready channel
// at one beat per cycle.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where the producer's valid and the consumer's ready are both high.
// While valid is high and ready is low, the producer holds valid and every
// payload bit stable. On the append channel, wr_ready does not depend on
// wr_valid.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   wr_valid/ready  append handshake; wr_k/wr_v carry the row
//   clear           one-cycle pulse that empties the cache and aborts a burst
//   rd_req          burst request, taken only while rd_req_ready is high
//   rd_start/len    first row index and row count of the burst
//   rd_valid/ready  beat handshake; rd_k/rd_v/rd_idx/rd_last are the payload
//   rd_err          one-cycle pulse in the cycle a request is rejected
//   fill, full      rows stored, and fill == SEQ_LEN
//   o_dbg_state     FSM state (0 = S_IDLE, 1 = S_FETCH, 2 = S_STREAM)
module kv_burst_cache #(
  parameter  int SEQ_LEN = 2048,
  parameter  int HEADS   = 12,
  parameter  int DW      = 4,
  localparam int RW      = HEADS * DW,
  localparam int AW      = $clog2(SEQ_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_k,
  input  logic [RW-1:0] wr_v,
  input  logic          clear,
  input  logic          rd_req,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_start,
  input  logic [AW:0]   rd_len,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [RW-1:0] rd_k,
  output logic [RW-1:0] rd_v,
  output logic [AW-1:0] rd_idx,
  output logic          rd_last,
  output logic          rd_err,
  output logic [AW:0]   fill,
  output logic          full,
  output logic [1:0]    o_dbg_state
);

  localparam logic [AW:0]   FILL_MAX = (AW+1)'(SEQ_LEN);
  localparam logic [AW:0]   ONE_L    = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  // One streamed beat. Both the prefetch buffer and the memory output stage
  // use this record.
  typedef struct packed {
    logic [RW-1:0] k;
    logic [RW-1:0] v;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  // Storage. The arrays are never reset.
  logic [RW-1:0] r_mem_k [SEQ_LEN];
  logic [RW-1:0] r_mem_v [SEQ_LEN];
  logic [RW-1:0] r_rdat_k;
  logic [RW-1:0] r_rdat_v;

  // Control state
  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_fill;
  logic [AW-1:0] r_iss_idx;    // next row to read from the arrays
  logic [AW:0]   r_iss_rem;    // rows of the burst not yet read
  logic          r_pend;       // a read was issued last cycle; r_rdat_* is live
  logic [AW-1:0] r_pend_idx;
  logic          r_pend_last;
  logic [1:0]    r_cnt;        // occupied prefetch entries (0..2)
  beat_t         r_b0;         // prefetch head
  beat_t         r_b1;

  logic          w_full;
  logic          w_wr_en;
  logic [AW+1:0] w_req_end;
  logic          w_req_bad;
  logic          w_accept;
  beat_t         w_mem_beat;
  beat_t         w_head;
  logic          w_head_valid;
  logic          w_pop;
  logic          w_fifo_pop;
  logic          w_push;
  logic [2:0]    w_left;
  logic          w_issue;

  // Append path
  assign w_full   = (r_fill == FILL_MAX);
  assign wr_ready = !w_full && !clear;
  assign w_wr_en  = wr_valid && wr_ready && !rst;
  assign fill     = r_fill;
  assign full     = w_full;

  // Request check. The add is one bit wider than rd_len so it cannot wrap.
  assign w_req_end = {2'b00, rd_start} + {1'b0, rd_len};
  assign w_req_bad = (rd_len == '0) || (w_req_end > {1'b0, r_fill});

  // The read pipeline is treated as one ordered queue: prefetch entries
  // first, then the row that just came out of the arrays. The head is served
  // straight from the array output when the buffer is empty. That bypass
  // gives valid two cycles after acceptance. A stalled array output moves
  // into the buffer on the same edge, so the presented beat does not change.
  assign w_mem_beat   = {r_rdat_k, r_rdat_v, r_pend_idx, r_pend_last};
  assign w_head_valid = (r_cnt != 2'd0) || r_pend;
  assign w_head       = (r_cnt != 2'd0) ? r_b0 : w_mem_beat;
  assign w_pop        = w_head_valid && rd_ready;
  assign w_fifo_pop   = w_pop && (r_cnt != 2'd0);
  assign w_push       = r_pend && !(w_pop && (r_cnt == 2'd0));

  // Entries still queued after this cycle's pop. A new read returns next
  // cycle, so it is issued only when the queue will have room for it. This
  // limits the buffer to two entries. It still allows one read per cycle
  // while the consumer keeps up.
  assign w_left  = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue = (r_state != S_IDLE) && (r_iss_rem != '0) && (w_left <= 3'd1);

  // Outputs are zero whenever no beat is presented.
  assign rd_valid    = w_head_valid;
  assign rd_k        = w_head_valid ? w_head.k   : '0;
  assign rd_v        = w_head_valid ? w_head.v   : '0;
  assign rd_idx      = w_head_valid ? w_head.idx : '0;
  assign rd_last     = w_head_valid && w_head.last;
  assign o_dbg_state = r_state;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and request outputs
  always_comb begin
    w_state_nxt  = r_state;
    rd_req_ready = 1'b0;
    rd_err       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        rd_req_ready = 1'b1;
        if (rd_req && !clear && !rst) begin
          if (w_req_bad) begin
            rd_err = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_pop && w_head.last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  // Arrays: one write port and one registered read port. A burst only reads
  // rows below the fill level it was checked against. Appends always land at
  // or above that level, so a concurrent write never aliases a burst read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_k[r_fill[AW-1:0]] <= wr_k;
      r_mem_v[r_fill[AW-1:0]] <= wr_v;
    end
    if (w_issue) begin
      r_rdat_k <= r_mem_k[r_iss_idx];
      r_rdat_v <= r_mem_v[r_iss_idx];
    end
  end

  // Control registers. Clear shares the reset path: it empties the cache
  // and drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_fill    <= '0;
      r_iss_idx <= '0;
      r_iss_rem <= '0;
      r_pend    <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_wr_en) r_fill <= r_fill + ONE_L;
      if (w_accept) begin
        r_iss_idx <= rd_start;
        r_iss_rem <= rd_len;
      end else if (w_issue) begin
        r_iss_idx <= r_iss_idx + ONE_A;
        r_iss_rem <= r_iss_rem - ONE_L;
      end
      r_pend <= w_issue;
      case ({w_fifo_pop, w_push})
        2'b10:   r_cnt <= r_cnt - 2'd1;
        2'b01:   r_cnt <= r_cnt + 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload registers. They are not reset; valid qualifies them.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_pend_idx  <= r_iss_idx;
      r_pend_last <= (r_iss_rem == ONE_L);
    end
    case ({w_fifo_pop, w_push})
      2'b10: r_b0 <= r_b1;
      2'b01: begin
        if (r_cnt == 2'd0) r_b0 <= w_mem_beat;
        else               r_b1 <= w_mem_beat;
      end
      2'b11: begin
        if (r_cnt == 2'd1) begin
          r_b0 <= w_mem_beat;
        end else begin
          r_b0 <= r_b1;
          r_b1 <= w_mem_beat;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kv_burst_cache.sv
// Testbench for kv_burst_cache. It runs directed scenarios with hand-computed
// expectations. A bench-side model of the cache (row arrays, fill count and a
// queue of expected beats per burst) is checked against the DUT every cycle.
module tb_kv_burst_cache;
  localparam int SEQ_LEN = 2048;
  localparam int HEADS   = 12;
  localparam int DW      = 4;
  localparam int RW      = HEADS * DW;
  localparam int AW      = $clog2(SEQ_LEN);
  localparam int BW      = 2 * RW + AW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, clear, rd_req, rd_req_ready;
  logic [RW-1:0] wr_k, wr_v, rd_k, rd_v;
  logic [AW-1:0] rd_start, rd_idx;
  logic [AW:0]   rd_len, fill;
  logic          rd_valid, rd_ready, rd_last, rd_err, full;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  kv_burst_cache #(.SEQ_LEN(SEQ_LEN), .HEADS(HEADS), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_k(wr_k), .wr_v(wr_v),
    .clear(clear),
    .rd_req(rd_req), .rd_req_ready(rd_req_ready), .rd_start(rd_start), .rd_len(rd_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_k(rd_k), .rd_v(rd_v),
    .rd_idx(rd_idx), .rd_last(rd_last), .rd_err(rd_err),
    .fill(fill), .full(full), .o_dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [RW-1:0] k_pat(input int i);
    logic [15:0] s;
    logic [63:0] w;
    s = i[15:0];
    w = {16'h0000, s, 16'hC0DE, s ^ 16'h5A5A};
    return w[RW-1:0];
  endfunction

  function automatic logic [RW-1:0] v_pat(input int i);
    return ~k_pat(i);
  endfunction

  function automatic bit req_bad(input int start, input int len, input int f);
    return (len == 0) || (start + len > f);
  endfunction

  // ---------------- behavioural model ----------------
  logic [RW-1:0] m_k [SEQ_LEN];
  logic [RW-1:0] m_v [SEQ_LEN];
  int            m_fill    = 0;
  bit            m_busy    = 0;
  int            m_age     = 0;
  bit            m_started = 0;
  bit            m_hs      = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] m_tmp;

  // Model update at every active edge, from the inputs driven for that cycle.
  always @(posedge clk) begin
    if (rst) m_started = 1'b1;
    if (rst || clear) begin
      m_fill = 0;
      m_busy = 0;
      m_age  = 0;
      exp_q.delete();
    end else begin
      if (m_busy) begin
        m_age++;
        if (m_hs && exp_q.size() > 0) begin
          m_tmp = exp_q.pop_front();
          if (m_tmp[0]) m_busy = 0;
        end
      end else if (rd_req && !req_bad(int'(rd_start), int'(rd_len), m_fill)) begin
        for (int i = 0; i < int'(rd_len); i++) begin
          m_tmp = {m_k[int'(rd_start) + i], m_v[int'(rd_start) + i],
                   AW'(int'(rd_start) + i), (i == int'(rd_len) - 1)};
          exp_q.push_back(m_tmp);
        end
        m_busy = 1;
        m_age  = 1;
      end
      if (wr_valid && m_fill < SEQ_LEN) begin
        m_k[m_fill] = wr_k;
        m_v[m_fill] = wr_v;
        m_fill++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic          c_exp_valid;
  logic          c_exp_err;
  logic [BW-1:0] c_head;

  always @(negedge clk) begin
    if (m_started) begin
      c_exp_valid = m_busy && (m_age >= 2) && (exp_q.size() > 0);
      c_exp_err   = rd_req && !m_busy && !clear && !rst &&
                    req_bad(int'(rd_start), int'(rd_len), m_fill);
      chk("m_fill", fill, m_fill);
      chk("m_full", full, (m_fill == SEQ_LEN));
      chk("m_wr_ready", wr_ready, (m_fill != SEQ_LEN) && !clear);
      chk("m_rd_req_ready", rd_req_ready, !m_busy);
      chk("m_rd_err", rd_err, c_exp_err);
      chk("m_rd_valid", rd_valid, c_exp_valid);
      if (c_exp_valid) begin
        c_head = exp_q[0];
        chk("m_rd_k", rd_k, c_head[BW-1 -: RW]);
        chk("m_rd_v", rd_v, c_head[BW-RW-1 -: RW]);
        chk("m_rd_idx", rd_idx, c_head[AW:1]);
        chk("m_rd_last", rd_last, c_head[0]);
      end
      m_hs = c_exp_valid && rd_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_rows(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      wr_valid = 1'b1;
      wr_k     = k_pat(i);
      wr_v     = v_pat(i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_one(input int start, output logic [RW-1:0] k,
                          output logic [AW-1:0] idx, output logic last, output bit got);
    rd_req   = 1'b1;
    rd_start = AW'(start);
    rd_len   = (AW+1)'(1);
    rd_ready = 1'b1;
    step();
    rd_req = 1'b0;
    got    = 0;
    k      = '0;
    idx    = '0;
    last   = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        got  = 1;
        k    = rd_k;
        idx  = rd_idx;
        last = rd_last;
      end
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fill"}, fill, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_rd_req_ready"}, rd_req_ready, 1);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
    chk({tag, "_rd_k"}, rd_k, 0);
    chk({tag, "_rd_v"}, rd_v, 0);
    chk({tag, "_rd_idx"}, rd_idx, 0);
  endtask

  // ---------------- directed stimulus ----------------
  int            beats, lasts, wi;
  bit            done, got;
  logic [RW-1:0] got_k;
  logic [AW-1:0] got_idx;
  logic          got_last;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_k = '0; wr_v = '0; clear = 1'b0;
    rd_req = 1'b0; rd_start = '0; rd_len = '0; rd_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_dbg_state_idle", dbg_state, 0);
    step();
    rst = 1'b0;

    // Three rows, then a 3-row burst with the consumer always ready.
    write_rows(0, 3);
    rd_req = 1'b1; rd_start = 0; rd_len = 3; rd_ready = 1'b1;
    @(negedge clk);
    chk("t1_req_ready", rd_req_ready, 1);
    chk("t1_err", rd_err, 0);
    step();
    rd_req = 1'b0;
    @(negedge clk);
    chk("t1_valid_c1", rd_valid, 0);
    step();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk("t1_valid", rd_valid, 1);
      chk("t1_idx", rd_idx, b);
      chk("t1_last", rd_last, (b == 2));
      chk("t1_k", rd_k, k_pat(b));
      if (b == 1) chk("t1_k_literal", rd_k, 48'h0001_C0DE_5A5B);
      step();
    end
    @(negedge clk);
    chk("t1_valid_after", rd_valid, 0);
    chk("t1_req_ready_after", rd_req_ready, 1);
    step();

    // Requests that run past fill, or ask for no rows, are rejected.
    rd_req = 1'b1; rd_start = 2; rd_len = 2;
    @(negedge clk);
    chk("t2_err_range", rd_err, 1);
    step();
    rd_start = 0; rd_len = 0;
    @(negedge clk);
    chk("t2_err_len0", rd_err, 1);
    step();
    rd_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_no_valid", rd_valid, 0);
      chk("t2_err_pulse", rd_err, 0);
      step();
    end

    // Burst of 4 with stalls. Appends continue above the burst range.
    write_rows(3, 7);
    rd_req = 1'b1; rd_start = 4; rd_len = 4;
    beats = 0; lasts = 0; wi = 10; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      wr_valid = 1'b1; wr_k = k_pat(wi); wr_v = v_pat(wi);
      rd_ready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 3 || c == 4) begin
        chk("t3_hold_valid", rd_valid, 1);
        chk("t3_hold_idx", rd_idx, 5);
        chk("t3_hold_k", rd_k, k_pat(5));
      end
      if (rd_valid && rd_ready) begin
        chk("t3_order", rd_idx, 4 + beats);
        beats++;
        if (rd_last) begin
          lasts++;
          done = 1;
        end
      end
      step();
      rd_req = 1'b0;
      wi++;
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    chk("t3_beats", beats, 4);
    chk("t3_lasts", lasts, 1);

    // Clear on the second beat of an 8-row burst.
    rd_req = 1'b1; rd_start = 0; rd_len = 8;
    step();
    rd_req = 1'b0;
    step();
    step();
    clear = 1'b1;
    @(negedge clk);
    chk("t4_second_beat", rd_idx, 1);
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("t4_valid_off", rd_valid, 0);
    chk("t4_no_last", rd_last, 0);
    chk("t4_fill0", fill, 0);
    step();
    rd_req = 1'b1; rd_start = 0; rd_len = 1;
    @(negedge clk);
    chk("t4_err_after_clear", rd_err, 1);
    step();
    rd_req = 1'b0;

    // Clear in the same cycle as an append and a valid request.
    write_rows(0, 2);
    clear = 1'b1; wr_valid = 1'b1; wr_k = k_pat(99); wr_v = v_pat(99);
    rd_req = 1'b1; rd_start = 0; rd_len = 1;
    @(negedge clk);
    chk("t5_wr_ready", wr_ready, 0);
    chk("t5_err", rd_err, 0);
    step();
    clear = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_fill", fill, 0);
      chk("t5_no_valid", rd_valid, 0);
      step();
    end

    // Reset in the middle of a burst, with an append in the same cycle.
    write_rows(0, 4);
    rd_req = 1'b1; rd_start = 0; rd_len = 4; rd_ready = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    step();
    rst = 1'b1; wr_valid = 1'b1; wr_k = k_pat(7); wr_v = v_pat(7);
    step();
    rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6");
    step();

    // Fill to capacity, then check that extra appends are dropped.
    write_rows(0, SEQ_LEN);
    @(negedge clk);
    chk("t7_full", full, 1);
    chk("t7_wr_ready", wr_ready, 0);
    chk("t7_fill", fill, SEQ_LEN);
    step();
    for (int c = 0; c < 3; c++) begin
      wr_valid = 1'b1; wr_k = '1; wr_v = '1;
      @(negedge clk);
      chk("t7_fill_hold", fill, SEQ_LEN);
      step();
    end
    wr_valid = 1'b0;
    read_one(0, got_k, got_idx, got_last, got);
    chk("t7_row0_got", got, 1);
    chk("t7_row0_k", got_k, 48'h0000_C0DE_5A5A);
    chk("t7_row0_last", got_last, 1);
    read_one(SEQ_LEN - 1, got_k, got_idx, got_last, got);
    chk("t7_top_got", got, 1);
    chk("t7_top_idx", got_idx, SEQ_LEN - 1);
    chk("t7_top_k", got_k, k_pat(SEQ_LEN - 1));
    rd_req = 1'b1; rd_start = AW'(SEQ_LEN - 8); rd_len = 9;
    @(negedge clk);
    chk("t7_err_overrun", rd_err, 1);
    step();
    rd_req = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
